// File: rtl/dram_dma.sv
// dram_dma: word copy engine driving one Tawas data RAM port.
// Optional fill mode is compiled in with DRAM_DMA_FILL_EN.
module dram_dma #(
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic             mem_cs,
    output logic             mem_wr,
    output logic [3:0]       mem_mask,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout
);

    localparam int WC_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_FIN
    } state_t;

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic [WC_W-1:0]  wcnt_q;
    logic [31:0]      src_al;
    logic [31:0]      dst_al;
    logic             unused_bits;

    assign src_al = {src_addr[31:2], 2'b00};
    assign dst_al = {dst_addr[31:2], 2'b00};

`ifdef DRAM_DMA_FILL_EN
    logic        fill_q;
    logic [31:0] fill_d_q;

    assign unused_bits = ^{src_addr[1:0], dst_addr[1:0]};
`else
    assign unused_bits = ^{src_addr[1:0], dst_addr[1:0], fill, fill_data};
`endif

    // Transfer sequencer; every port output is driven from this register set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_addr <= '0;
            mem_cs   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_mask <= 4'h0;
            mem_din  <= '0;
`ifdef DRAM_DMA_FILL_EN
            fill_q   <= 1'b0;
            fill_d_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                cnt_q    <= '0;
                wcnt_q   <= '0;
                mem_cs   <= 1'b0;
                mem_wr   <= 1'b0;
                mem_mask <= 4'h0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !done) begin
                            src_q <= src_al;
                            dst_q <= dst_al;
                            cnt_q <= len_words;
`ifdef DRAM_DMA_FILL_EN
                            fill_q   <= fill;
                            fill_d_q <= fill_data;
`endif
                            if (len_words == '0) begin
                                state <= S_FIN;
                            end else begin
                                busy <= 1'b1;
`ifdef DRAM_DMA_FILL_EN
                                if (fill) begin
                                    state    <= S_WR;
                                    mem_cs   <= 1'b1;
                                    mem_wr   <= 1'b1;
                                    mem_mask <= 4'hF;
                                    mem_addr <= dst_al;
                                    mem_din  <= fill_data;
                                end else
`endif
                                begin
                                    state    <= S_RD;
                                    mem_cs   <= 1'b1;
                                    mem_addr <= src_al;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        if (RD_LAT == 1) begin
                            state    <= S_WR;
                            mem_wr   <= 1'b1;
                            mem_mask <= 4'hF;
                            mem_addr <= dst_q;
                            mem_din  <= mem_dout;
                        end else begin
                            state  <= S_WAIT;
                            mem_cs <= 1'b0;
                            wcnt_q <= WC_W'(RD_LAT - 2);
                        end
                    end
                    S_WAIT: begin
                        if (wcnt_q == '0) begin
                            state    <= S_WR;
                            mem_cs   <= 1'b1;
                            mem_wr   <= 1'b1;
                            mem_mask <= 4'hF;
                            mem_addr <= dst_q;
                            mem_din  <= mem_dout;
                        end else begin
                            wcnt_q <= wcnt_q - 1'b1;
                        end
                    end
                    S_WR: begin
                        src_q    <= src_q + 32'd4;
                        dst_q    <= dst_q + 32'd4;
                        cnt_q    <= cnt_q - 1'b1;
                        mem_cs   <= 1'b0;
                        mem_wr   <= 1'b0;
                        mem_mask <= 4'h0;
                        if (cnt_q == LEN_W'(1)) begin
                            state <= S_FIN;
                        end else begin
`ifdef DRAM_DMA_FILL_EN
                            if (fill_q) begin
                                state    <= S_WR;
                                mem_cs   <= 1'b1;
                                mem_wr   <= 1'b1;
                                mem_mask <= 4'hF;
                                mem_addr <= dst_q + 32'd4;
                                mem_din  <= fill_d_q;
                            end else
`endif
                            begin
                                state    <= S_RD;
                                mem_cs   <= 1'b1;
                                mem_addr <= src_q + 32'd4;
                            end
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
